// File: rtl/ibex_lsu_resp_stage_pkg.sv
// Shared types for the LSU response stage: the per-request descriptor and the
// split-merge FSM state encoding.
package ibex_lsu_resp_stage_pkg;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sign_ext;
    logic [1:0] offset;
    logic       split;
  } lsu_resp_desc_t;

  typedef enum logic {
    LSU_RESP_IDLE,
    LSU_RESP_WAIT_2ND
  } lsu_resp_state_e;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

endpackage

// File: rtl/ibex_lsu_resp_stage_if.sv
// Request-grant and data-bus response bundle feeding the LSU response stage.
// master = LSU/bus side driving requests and responses, slave = response stage.
interface ibex_lsu_resp_stage_if;
  logic        req_push;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign_ext;
  logic [1:0]  req_offset;
  logic        req_split;
  logic        req_full;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output req_push, req_we, req_size, req_sign_ext, req_offset, req_split,
    output data_rvalid, data_rdata, data_err,
    input  req_full
  );

  modport slave (
    input  req_push, req_we, req_size, req_sign_ext, req_offset, req_split,
    input  data_rvalid, data_rdata, data_err,
    output req_full
  );
endinterface

// File: rtl/ibex_lsu_resp_fifo.sv
// In-order descriptor queue; a separate count distinguishes full from empty
// since the wrapping pointers alone cannot.
module ibex_lsu_resp_fifo
  import ibex_lsu_resp_stage_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0,
  localparam int unsigned PtrW    = $clog2(Depth),
  localparam int unsigned CntW    = $clog2(Depth) + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  lsu_resp_desc_t wdata_i,
  input  logic           pop_i,
  output lsu_resp_desc_t rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  lsu_resp_desc_t  mem_q [Depth];
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  if (ResetAll) begin : g_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ibex_lsu_resp_stage.sv
// LSU response stage: pops descriptors on bus responses, merges split halves,
// aligns/extends load data. Define IBEX_LSU_RESP_REG_EN to register completion outputs.
module ibex_lsu_resp_stage
  import ibex_lsu_resp_stage_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  ibex_lsu_resp_stage_if.slave              bus,
  output logic                              rf_we_lsu_o,
  output logic [31:0]                       rf_wdata_lsu_o,
  output logic                              lsu_resp_valid_o,
  output logic                              lsu_resp_err_o,
  output logic [$clog2(NumOutstanding):0]   outstanding_o,
  output logic                              spurious_resp_o
);

  function automatic logic [31:0] align_load(lsu_resp_desc_t d, logic [31:0] hold,
                                             logic [31:0] rdata);
    logic [63:0]        win;
    logic [31:0]        sh;
    logic signed [31:0] ext;
    win = d.split ? {rdata, hold} : {32'h0, rdata};
    sh  = 32'(win >> {d.offset, 3'b000});
    unique case (d.size)
      LSU_SIZE_BYTE: ext = d.sign_ext ? 32'($signed(sh[7:0]))  : 32'(sh[7:0]);
      LSU_SIZE_HALF: ext = d.sign_ext ? 32'($signed(sh[15:0])) : 32'(sh[15:0]);
      default:       ext = sh;
    endcase
    return ext;
  endfunction

  lsu_resp_desc_t  head, push_desc;
  lsu_resp_state_e state_q;
  logic            empty, full;
  logic            rsp_fire, first_half, vld_p0, err_p0, we_p0;
  logic [31:0]     wdata_p0, hold_rdata_q;
  logic            hold_err_q;

  assign push_desc = '{we: bus.req_we, size: bus.req_size, sign_ext: bus.req_sign_ext,
                       offset: bus.req_offset, split: bus.req_split};

  ibex_lsu_resp_fifo #(
    .Depth   (NumOutstanding),
    .ResetAll(ResetAll)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (bus.req_push),
    .wdata_i(push_desc),
    .pop_i  (vld_p0),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(outstanding_o)
  );

  assign bus.req_full    = full;
  assign spurious_resp_o = bus.data_rvalid & empty;
  assign rsp_fire        = bus.data_rvalid & ~empty;
  assign first_half      = rsp_fire & (state_q == LSU_RESP_IDLE) & head.split;

  // Stage p0: completion decode in the response cycle
  assign vld_p0   = rsp_fire & ~first_half;
  assign err_p0   = vld_p0 & (bus.data_err | (head.split & hold_err_q));
  assign we_p0    = vld_p0 & ~head.we & ~err_p0;
  assign wdata_p0 = we_p0 ? align_load(head, hold_rdata_q, bus.data_rdata) : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_RESP_IDLE;
    end else if (first_half) begin
      state_q <= LSU_RESP_WAIT_2ND;
    end else if (vld_p0) begin
      state_q <= LSU_RESP_IDLE;
    end
  end

  if (ResetAll) begin : g_hold_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hold_rdata_q <= '0;
        hold_err_q   <= 1'b0;
      end else if (first_half) begin
        hold_rdata_q <= bus.data_rdata;
        hold_err_q   <= bus.data_err;
      end
    end
  end else begin : g_hold_norst
    always_ff @(posedge clk_i) begin
      if (first_half) begin
        hold_rdata_q <= bus.data_rdata;
        hold_err_q   <= bus.data_err;
      end
    end
  end

`ifdef IBEX_LSU_RESP_REG_EN
  // Stage p1: registered completion towards writeback
  logic        vld_p1, err_p1, we_p1;
  logic [31:0] wdata_p1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      we_p1    <= 1'b0;
      wdata_p1 <= '0;
    end else begin
      vld_p1   <= vld_p0;
      err_p1   <= err_p0;
      we_p1    <= we_p0;
      wdata_p1 <= wdata_p0;
    end
  end
  assign lsu_resp_valid_o = vld_p1;
  assign lsu_resp_err_o   = err_p1;
  assign rf_we_lsu_o      = we_p1;
  assign rf_wdata_lsu_o   = wdata_p1;
`else
  assign lsu_resp_valid_o = vld_p0;
  assign lsu_resp_err_o   = err_p0;
  assign rf_we_lsu_o      = we_p0;
  assign rf_wdata_lsu_o   = wdata_p0;
`endif

  push_while_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      !(bus.req_push && full));

endmodule
